// File: rtl/mean_filter_pkg.sv
// Shared elaboration-time helpers for the mean-filter chain.
// Purpose: derive the reciprocal-multiply constants used by the mean
// dividers. The package has no ports. It provides clog2, the fraction-bit
// count, the reciprocal, the rounding bias and the legal-kernel check.
package mean_filter_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // One guard bit beyond IW + clog2(N) makes the reciprocal exact for
    // every sum below 2^IW + N.
    function automatic int avg_frac_bits(input int iw, input int ksz);
        return iw + clog2(ksz * ksz) + 1;
    endfunction

    // ceil(2^f / N)
    function automatic longint avg_recip(input int ksz, input int f);
        longint n;
        n = longint'(ksz * ksz);
        return ((longint'(1) << f) + n - 1) / n;
    endfunction

    // floor(N/2) turns the floor division into round-half-up.
    function automatic int avg_bias(input int ksz, input int rnd);
        return (rnd != 0) ? (ksz * ksz) / 2 : 0;
    endfunction

    function automatic bit ksz_legal(input int ksz);
        return (ksz % 2 == 1) && (ksz >= 3) && (ksz <= 15);
    endfunction

endpackage

// File: rtl/div_avg_ch.sv
// One channel of the mean divider: S1 bias add, S2 reciprocal multiply,
// S3 product register, S4 shift/saturate register.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   vld[3:0]   : load enable of S1..S4 (shared across channels)
//   x          : kernel sum for this channel
//   q          : S4 quotient (saturated)
//   sat        : S3 content saturates; it is loaded into S4 when vld[3] is high
module div_avg_ch
    import mean_filter_pkg::*;
#(
    parameter int KSZ = 3,
    parameter int DW  = 8,
    parameter int IW  = 16,
    parameter int RND = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    vld,
    input  logic [IW-1:0] x,
    output logic [DW-1:0] q,
    output logic          sat
);
    localparam int F  = avg_frac_bits(IW, KSZ);
    localparam int PW = IW + 1 + F + 1;
    localparam logic [PW-1:0] M    = PW'(avg_recip(KSZ, F));
    localparam logic [IW:0]   B    = (IW + 1)'(avg_bias(KSZ, RND));
    localparam logic [PW-1:0] QMAX = PW'((1 << DW) - 1);

    logic [IW:0]   s1;
    logic [PW-1:0] s2;
    logic [PW-1:0] s3;
    logic [PW-1:0] quo;

    assign quo = s3 >> F;
    assign sat = (quo > QMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            q  <= '0;
        end else begin
            if (vld[0]) s1 <= {1'b0, x} + B;
            if (vld[1]) s2 <= PW'(s1) * M;
            if (vld[2]) s3 <= s2;
            if (vld[3]) q  <= sat ? '1 : quo[DW-1:0];
        end
    end

endmodule

// File: rtl/div_avg_mc.sv
// Pipelined multi-channel mean divider: dout = kernel sum / KSZ^2. It has a
// fixed 4-clock latency and accepts one sample per clock.
// Ports:
//   clk, rst_n             : clock, async active-low reset
//   din_vsync, din_hsync   : input field / line valid (hsync qualifies din)
//   din [CH*IW]            : per-channel sums, channel c at [c*IW +: IW]
//   dout_vsync, dout_hsync : syncs delayed by 4 clocks
//   dout [CH*DW]           : per-channel means, 0 while dout_hsync is low
//   ovf                    : sticky per-frame saturation flag
module div_avg_mc
    import mean_filter_pkg::*;
#(
    parameter int KSZ = 3,
    parameter int DW  = 8,
    parameter int IW  = 2 * DW,
    parameter int CH  = 1,
    parameter int RND = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_vsync,
    input  logic             din_hsync,
    input  logic [CH*IW-1:0] din,
    output logic             dout_vsync,
    output logic             dout_hsync,
    output logic [CH*DW-1:0] dout,
    output logic             ovf
);
    if (!ksz_legal(KSZ)) begin : g_bad_ksz
        $error("div_avg_mc: KSZ must be odd and within 3..15");
    end

    logic [3:0]       hs_d;
    logic [3:0]       vs_d;
    logic [CH-1:0]    sat;
    logic [CH*DW-1:0] dout_raw;
    logic             ovf_q;

    // Syncs are delayed unconditionally so that they act as the stage valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_d <= '0;
            vs_d <= '0;
        end else begin
            hs_d <= {hs_d[2:0], din_hsync};
            vs_d <= {vs_d[2:0], din_vsync};
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        div_avg_ch #(
            .KSZ (KSZ),
            .DW  (DW),
            .IW  (IW),
            .RND (RND)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .vld   ({hs_d[2:0], din_hsync}),
            .x     (din[c*IW +: IW]),
            .q     (dout_raw[c*DW +: DW]),
            .sat   (sat[c])
        );
    end

    // When a saturating S4 load and a field start fall in the same cycle,
    // the set takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (hs_d[2] && (|sat)) begin
            ovf_q <= 1'b1;
        end else if (din_vsync && !vs_d[0]) begin
            ovf_q <= 1'b0;
        end
    end

    assign dout_hsync = hs_d[3];
    assign dout_vsync = vs_d[3];
    assign dout       = hs_d[3] ? dout_raw : '0;
    assign ovf        = ovf_q;

endmodule

// File: doc/div_avg_mc.md
# div_avg_mc

Pipelined multi-channel mean divider for the mean-filter chain. It takes per-channel 2-D kernel sums with their field/line syncs and divides each sum by KSZ². Division uses an exact reciprocal multiply, with selectable truncate or round-to-nearest and output saturation. It replaces the fixed 3/5/7 shift-add divider and sits directly after the 2-D summation stage.

## Interface
Parameters:
- `KSZ`, 3: kernel edge length, odd, 3..15; divisor N = KSZ².
- `DW`, 8: output data width per channel.
- `IW`, 2*DW: input sum width per channel.
- `CH`, 1: channel count, 1..4.
- `RND`, 0: rounding mode; 0 = truncate (floor), 1 = round half up.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `din_vsync` input 1: input field valid.
- `din_hsync` input 1: input line valid; qualifies `din`.
- `din` input CH*IW: channel c occupies bits [c*IW +: IW].
- `dout_vsync` output 1: output field valid.
- `dout_hsync` output 1: output line valid.
- `dout` output CH*DW: channel c occupies bits [c*DW +: DW]. Forced to 0 whenever `dout_hsync` is low.
- `ovf` output 1: sticky per-frame flag; set if any channel saturated in the current frame.

## Operation
- Constants, all elaboration-time:
  - N = KSZ*KSZ.
  - F = IW + clog2(N) + 1.
  - M = ceil(2^F / N).
  - B = RND ? floor(N/2) : 0.
- Per channel, for sum x: q = ((x + B) * M) >> F. This equals floor((x+B)/N) exactly for every x < 2^IW + N.
- Widths:
  - x + B is carried in IW+1 bits.
  - The product is carried in IW+1+F+1 bits; no intermediate truncation.
- Saturation: if q > 2^DW−1, the output is 2^DW−1 and a per-channel sat bit is raised. For in-range sums (x ≤ N·(2^DW−1)) saturation never occurs, in either RND mode.
- Pipeline stages, each a register bank enabled only by the valid bit travelling with it:
  - S1: x + B.
  - S2: multiply by M.
  - S3: product register, for DSP retiming.
  - S4: shift by F, saturate, register.
- Stages hold their contents while their valid is low. Data gaps inside a line do not corrupt in-flight samples.
- `ovf`:
  - Cleared on the cycle after a rising edge of `din_vsync`.
  - Set when an S4 register load has any channel's sat bit high.
  - A clear and a set in the same cycle resolve to set.
- All channels share one valid/sync pipeline; channels never skew.

## Timing
- Fixed latency of 4 clocks: `dout_hsync`/`dout_vsync` at cycle t+4 equal `din_hsync`/`din_vsync` at cycle t. Data follows the same alignment.
- Throughput is one sample per clock; back-to-back `din_hsync` is supported indefinitely.
- Reset values: all sync delay bits 0, all datapath registers 0, `dout` = 0, `ovf` = 0.
- Reset asserted mid-line flushes the pipeline immediately. Outputs read 0 from reset assertion until four clocks after the first post-reset `din_hsync`.
- Sync signals are delayed unconditionally, without valid gating. `din_vsync` falling with samples still in flight lets those samples complete normally.

## Structure
- Shared package `mean_filter_pkg`:
  - `clog2` function.
  - Functions `avg_frac_bits(IW,KSZ)`, `avg_recip(KSZ,F)` and `avg_bias(KSZ,RND)`.
  - Legal-KSZ check; elaboration error on even KSZ or KSZ outside 3..15.
- Sub-module `div_avg_ch`:
  - One channel's S1–S4 datapath plus its sat bit, driven by the shared stage-valid vector.
  - Instantiated CH times via generate.
- The top level holds the sync delay line, the `ovf` logic and the output zero-gating.

## Test plan
- KSZ=3, DW=8, RND=0: inputs 2295, 17, 0 on consecutive clocks → outputs 255, 1, 0 exactly 4 clocks later, with `dout_hsync` high for 3 clocks.
- KSZ=3, RND=1: sum 17 → 2; sum 13 → 1 (1.44). KSZ=5, RND=1: 637 → 25, 638 → 26.
- KSZ=7, DW=8, CH=3: channel sums 12495/0/6272 → 255/0/128. Exhaustive sweep of x = 0..N·255 in both RND modes matches a golden floor/round model.
- KSZ=3, IW=16, DW=8: sum 65535 → 255 and `ovf`=1. `ovf` stays 1 to frame end and reads 0 the cycle after the next `din_vsync` rise. A saturating sample in that same cycle keeps `ovf`=1.
- `din_hsync` pattern 1,0,0,1,1 with distinct sums → identical pattern 4 clocks later with correct values; `dout` is 0 in the gaps.
- `rst_n` pulsed low during a line with 3 samples in flight → all outputs 0 immediately. The first post-reset sample appears after exactly 4 clocks.
